// File: rtl/riscv_csr_pkg.sv
// rtl/riscv_csr_pkg.sv - shared CSR addresses, mstatus bit positions and trap sequencer states
package riscv_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRAP_SAVE,
        ST_TRAP_STATUS,
        ST_MRET,
        ST_REDIRECT
    } trap_state_t;

endpackage

// File: rtl/trap_vector_calc.sv
// rtl/trap_vector_calc.sv - combinational trap target from mtvec and mcause
module trap_vector_calc #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] cause,
    output logic [XLEN-1:0] target
);

    logic [XLEN-1:0] base;

    // Only vectored mode (01) with an interrupt cause offsets the base; reserved modes fall back to direct.
    always_comb begin
        base = {mtvec[XLEN-1:2], 2'b00};
        if (mtvec[1:0] == 2'b01 && cause[XLEN-1]) begin
            target = base + {{(XLEN-6){1'b0}}, cause[3:0], 2'b00};
        end else begin
            target = base;
        end
    end

endmodule

// File: rtl/csr_trap_unit.sv
// rtl/csr_trap_unit.sv - machine-mode trap/mret sequencer driving the three-port CSR file
module csr_trap_unit
    import riscv_csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret_req,
    output logic            busy,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [11:0]     csr_addr1,
    output logic [11:0]     csr_addr2,
    output logic [11:0]     csr_addr3,
    output logic            csr_we1,
    output logic            csr_we2,
    output logic            csr_we3,
    output logic [XLEN-1:0] csr_wd1,
    output logic [XLEN-1:0] csr_wd2,
    output logic [XLEN-1:0] csr_wd3,
    input  logic [XLEN-1:0] csr_rd1,
    input  logic [XLEN-1:0] csr_rd2,
    input  logic [XLEN-1:0] csr_rd3
);

    trap_state_t     state_q, state_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [XLEN-1:0] vec_target;
    logic [XLEN-1:0] mstatus_new;
    logic            unused_inputs;

    assign unused_inputs = ^{csr_rd3, trap_pc[1:0]};
    assign redirect_pc   = redirect_pc_q;

    trap_vector_calc #(.XLEN(XLEN)) u_vec (
        .mtvec  (csr_rd2),
        .cause  (cause_q),
        .target (vec_target)
    );

    // Outputs are held at zero while rst is high so an aborted sequence commits nothing further.
    always_comb begin
        state_d        = state_q;
        cause_d        = cause_q;
        pc_d           = pc_q;
        tval_d         = tval_q;
        redirect_pc_d  = redirect_pc_q;
        busy           = 1'b0;
        redirect_valid = 1'b0;
        csr_addr1      = '0;
        csr_addr2      = '0;
        csr_addr3      = '0;
        csr_we1        = 1'b0;
        csr_we2        = 1'b0;
        csr_we3        = 1'b0;
        csr_wd1        = '0;
        csr_wd2        = '0;
        csr_wd3        = '0;
        mstatus_new    = csr_rd1;
        if (!rst) begin
            busy = (state_q != ST_IDLE);
            unique case (state_q)
                ST_IDLE: begin
                    if (trap_req) begin
                        cause_d = trap_cause;
                        pc_d    = {trap_pc[XLEN-1:2], 2'b00};
                        tval_d  = trap_tval;
                        state_d = ST_TRAP_SAVE;
                    end else if (mret_req) begin
                        state_d = ST_MRET;
                    end
                end
                ST_TRAP_SAVE: begin
                    csr_addr1 = CSR_MEPC;
                    csr_we1   = 1'b1;
                    csr_wd1   = pc_q;
                    csr_addr2 = CSR_MCAUSE;
                    csr_we2   = 1'b1;
                    csr_wd2   = cause_q;
                    csr_addr3 = CSR_MTVAL;
                    csr_we3   = 1'b1;
                    csr_wd3   = tval_q;
                    state_d   = ST_TRAP_STATUS;
                end
                ST_TRAP_STATUS: begin
                    mstatus_new[MSTATUS_MPIE]                  = csr_rd1[MSTATUS_MIE];
                    mstatus_new[MSTATUS_MIE]                   = 1'b0;
                    mstatus_new[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                    csr_addr1     = CSR_MSTATUS;
                    csr_we1       = 1'b1;
                    csr_wd1       = mstatus_new;
                    csr_addr2     = CSR_MTVEC;
                    redirect_pc_d = vec_target;
                    state_d       = ST_REDIRECT;
                end
                ST_MRET: begin
                    mstatus_new[MSTATUS_MIE]                   = csr_rd1[MSTATUS_MPIE];
                    mstatus_new[MSTATUS_MPIE]                  = 1'b1;
                    mstatus_new[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                    csr_addr1     = CSR_MSTATUS;
                    csr_we1       = 1'b1;
                    csr_wd1       = mstatus_new;
                    csr_addr2     = CSR_MEPC;
                    redirect_pc_d = {csr_rd2[XLEN-1:2], 2'b00};
                    state_d       = ST_REDIRECT;
                end
                ST_REDIRECT: begin
                    redirect_valid = 1'b1;
                    state_d        = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cause_q       <= '0;
            pc_q          <= '0;
            tval_q        <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            cause_q       <= cause_d;
            pc_q          <= pc_d;
            tval_q        <= tval_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

endmodule

// File: tb/tb_csr_trap_unit.sv
// tb/tb_csr_trap_unit.sv - directed scoreboard bench for csr_trap_unit with a behavioural CSR file
module tb_csr_trap_unit;
    import riscv_csr_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_req, mret_req;
    logic [31:0] trap_cause, trap_pc, trap_tval;
    logic        busy, redirect_valid;
    logic [31:0] redirect_pc;
    logic [11:0] csr_addr1, csr_addr2, csr_addr3;
    logic        csr_we1, csr_we2, csr_we3;
    logic [31:0] csr_wd1, csr_wd2, csr_wd3;
    logic [31:0] csr_rd1, csr_rd2, csr_rd3;

    logic        pl_we = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [31:0] pl_data = '0;
    logic [31:0] mem [0:4095];

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wq[$];
    logic [31:0] rq[$];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    csr_trap_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
        .mret_req(mret_req), .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .csr_addr1(csr_addr1), .csr_addr2(csr_addr2), .csr_addr3(csr_addr3),
        .csr_we1(csr_we1), .csr_we2(csr_we2), .csr_we3(csr_we3),
        .csr_wd1(csr_wd1), .csr_wd2(csr_wd2), .csr_wd3(csr_wd3),
        .csr_rd1(csr_rd1), .csr_rd2(csr_rd2), .csr_rd3(csr_rd3)
    );

    assign csr_rd1 = mem[csr_addr1];
    assign csr_rd2 = mem[csr_addr2];
    assign csr_rd3 = mem[csr_addr3];

    always @(posedge clk) begin
        if (pl_we)   mem[pl_addr]   <= pl_data;
        if (csr_we1) mem[csr_addr1] <= csr_wd1;
        if (csr_we2) mem[csr_addr2] <= csr_wd2;
        if (csr_we3) mem[csr_addr3] <= csr_wd3;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mon_write(input int port, input logic [11:0] addr, input logic [31:0] data);
        wr_t e;
        if (wq.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL unexpected_write: port %0d addr %h data %h, none expected", port, addr, data);
        end else begin
            e = wq.pop_front();
            check($sformatf("wr_addr_p%0d", port), {20'b0, addr}, {20'b0, e.addr});
            check($sformatf("wr_data_p%0d", port), data, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (csr_we1) mon_write(1, csr_addr1, csr_wd1);
        if (csr_we2) mon_write(2, csr_addr2, csr_wd2);
        if (csr_we3) mon_write(3, csr_addr3, csr_wd3);
        if (redirect_valid) begin
            if (rq.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL unexpected_redirect: pc %h, none expected", redirect_pc);
            end else begin
                check("redirect_pc_sb", redirect_pc, rq.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pl_addr = a;
        pl_data = d;
        pl_we   = 1'b1;
        step();
        pl_we   = 1'b0;
    endtask

    task automatic push_w(input logic [11:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        wq.push_back(e);
    endtask

    task automatic push_trap(input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] tval,
                             input logic [31:0] status, input logic [31:0] target);
        push_w(CSR_MEPC, {pc[31:2], 2'b00});
        push_w(CSR_MCAUSE, cause);
        push_w(CSR_MTVAL, tval);
        push_w(CSR_MSTATUS, status);
        rq.push_back(target);
    endtask

    task automatic run_trap(input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] tval,
                            input logic [31:0] status, input logic [31:0] target, input logic with_mret);
        push_trap(cause, pc, tval, status, target);
        trap_req = 1'b1; mret_req = with_mret;
        trap_cause = cause; trap_pc = pc; trap_tval = tval;
        step();
        trap_req = 1'b0; mret_req = 1'b0;
        trap_cause = ~cause; trap_pc = ~pc; trap_tval = ~tval;
        check("save_busy", {31'b0, busy}, 1);
        check("save_rv", {31'b0, redirect_valid}, 0);
        step();
        check("status_busy", {31'b0, busy}, 1);
        check("status_rv", {31'b0, redirect_valid}, 0);
        step();
        check("redir_rv", {31'b0, redirect_valid}, 1);
        check("redir_pc", redirect_pc, target);
        step();
        check("post_trap_busy", {31'b0, busy}, 0);
        check("post_trap_rv", {31'b0, redirect_valid}, 0);
    endtask

    task automatic run_mret(input logic [31:0] status, input logic [31:0] target);
        push_w(CSR_MSTATUS, status);
        rq.push_back(target);
        mret_req = 1'b1;
        step();
        mret_req = 1'b0;
        check("mret_busy", {31'b0, busy}, 1);
        check("mret_rv", {31'b0, redirect_valid}, 0);
        step();
        check("mret_redir_rv", {31'b0, redirect_valid}, 1);
        check("mret_redir_pc", redirect_pc, target);
        step();
        check("post_mret_busy", {31'b0, busy}, 0);
    endtask

    initial begin
        rst = 1'b1; trap_req = 1'b0; mret_req = 1'b0;
        trap_cause = '0; trap_pc = '0; trap_tval = '0;

        // Reset held while the CSR file is preloaded; outputs must stay at zero throughout.
        preload(CSR_MTVEC, 32'h0000_1000);
        preload(CSR_MSTATUS, 32'h0000_0008);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_we_rv", {28'b0, csr_we1, csr_we2, csr_we3, redirect_valid}, 0);
        check("rst_addr", {20'b0, csr_addr1 | csr_addr2 | csr_addr3}, 0);
        check("rst_wd", csr_wd1 | csr_wd2 | csr_wd3, 0);
        check("rst_redirect_pc", redirect_pc, 0);
        rst = 1'b0;
        repeat (10) step();
        check("idle_busy", {31'b0, busy}, 0);

        // ecall
        run_trap(32'd11, 32'h0000_0204, 32'h0, 32'h0000_1880, 32'h0000_1000, 1'b0);
        check("ecall_mstatus", mem[CSR_MSTATUS], 32'h0000_1880);
        check("ecall_mepc", mem[CSR_MEPC], 32'h0000_0204);

        // Vectored interrupt, reserved mode, and vectored mode with an exception cause
        preload(CSR_MTVEC, 32'h0000_2001);
        run_trap(32'h8000_0007, 32'h0000_3003, 32'h0000_DEAD, 32'h0000_1800, 32'h0000_201C, 1'b0);
        check("vec_mepc_aligned", mem[CSR_MEPC], 32'h0000_3000);
        preload(CSR_MTVEC, 32'h0000_2003);
        run_trap(32'h8000_0007, 32'h0000_0100, 32'h0, 32'h0000_1800, 32'h0000_2000, 1'b0);
        preload(CSR_MTVEC, 32'h0000_2001);
        run_trap(32'd11, 32'h0000_0104, 32'h0, 32'h0000_1800, 32'h0000_2000, 1'b0);

        // mret
        preload(CSR_MEPC, 32'h0000_0208);
        preload(CSR_MSTATUS, 32'h0000_1880);
        run_mret(32'h0000_1888, 32'h0000_0208);
        check("mret_mstatus", mem[CSR_MSTATUS], 32'h0000_1888);

        // Simultaneous trap and mret: trap wins
        preload(CSR_MTVEC, 32'h0000_1000);
        run_trap(32'd2, 32'h0000_0400, 32'h0000_1234, 32'h0000_1880, 32'h0000_1000, 1'b1);
        step();
        check("dropped_mret_busy", {31'b0, busy}, 0);

        // Request held through the sequence is re-accepted only from IDLE
        push_trap(32'd3, 32'h0000_0500, 32'h11, 32'h0000_1800, 32'h0000_1000);
        push_trap(32'd3, 32'h0000_0500, 32'h11, 32'h0000_1800, 32'h0000_1000);
        trap_req = 1'b1; trap_cause = 32'd3; trap_pc = 32'h0000_0500; trap_tval = 32'h11;
        step();
        check("held_n1_busy", {31'b0, busy}, 1);
        step();
        step();
        check("held_n3_rv", {31'b0, redirect_valid}, 1);
        step();
        check("held_n4_busy", {31'b0, busy}, 0);
        step();
        check("held_n5_busy", {31'b0, busy}, 1);
        trap_req = 1'b0;
        step();
        step();
        check("held_n7_rv", {31'b0, redirect_valid}, 1);
        step();
        check("held_n8_busy", {31'b0, busy}, 0);

        // Reset during TRAP_STATUS aborts the mstatus write and the redirect
        preload(CSR_MSTATUS, 32'h0000_0008);
        push_w(CSR_MEPC, 32'h0000_0600);
        push_w(CSR_MCAUSE, 32'd5);
        push_w(CSR_MTVAL, 32'h77);
        trap_req = 1'b1; trap_cause = 32'd5; trap_pc = 32'h0000_0600; trap_tval = 32'h77;
        step();
        trap_req = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("abort_we1", {31'b0, csr_we1}, 0);
        step();
        rst = 1'b0;
        #1;
        check("abort_idle_busy", {31'b0, busy}, 0);
        repeat (4) step();
        check("abort_busy_later", {31'b0, busy}, 0);
        check("abort_mstatus", mem[CSR_MSTATUS], 32'h0000_0008);
        check("abort_mcause", mem[CSR_MCAUSE], 32'd5);

        check("wq_empty", 32'(wq.size()), 0);
        check("rq_empty", 32'(rq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
